// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed seven-segment scan controller:
// FSM state encoding and the active-low hex segment table (bit0=a .. bit6=g).
package display_scan_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ON    = 2'd1;
    localparam state_t ST_BLANK = 2'd2;

    // Entry 15 is written first so that SEG_TABLE[n] selects the glyph for nibble n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/display_scan_ctrl_seg7_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_decode
    import display_scan_ctrl_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = SEG_TABLE[nibble];

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed seven-segment display scanner with per-digit dead time,
// frame-synchronous value updates and optional leading-zero suppression.
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIVISOR = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter bit LZS          = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    output logic [DIGITS-1:0]     an_n,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic                  frame_done
);

    localparam int MAX_DWELL = (SCAN_DIVISOR > BLANK_CYCLES) ? SCAN_DIVISOR : BLANK_CYCLES;
    localparam int CW = $clog2(MAX_DWELL) + 1;
    localparam int IW = $clog2(DIGITS);

    localparam logic [CW-1:0]     ON_LAST    = CW'(SCAN_DIVISOR - 1);
    localparam logic [CW-1:0]     BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IW-1:0]     LAST_DIGIT = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] DIGIT0_SEL = DIGITS'(1);

    state_t                state, state_nx;
    logic [IW-1:0]         index, index_nx, index_inc;
    logic [CW-1:0]         cnt, cnt_nx;
    logic                  wrap;

    logic [4*DIGITS-1:0]   shadow_value, shadow_value_nx;
    logic [DIGITS-1:0]     shadow_dp, shadow_dp_nx;
    logic [4*DIGITS-1:0]   pending_value, pending_value_nx;
    logic [DIGITS-1:0]     pending_dp, pending_dp_nx;
    logic                  pending_valid, pending_valid_nx;

    logic [DIGITS-1:0]     suppress;
    logic                  zero_above;
    logic [3:0]            cur_nibble;
    logic [6:0]            dec_seg;
    logic                  last_cycle_nx;

    logic [DIGITS-1:0]     an_n_nx;
    logic [6:0]            seg_n_nx;
    logic                  dp_n_nx;
    logic                  frame_done_nx;

    assign index_inc = (index == LAST_DIGIT) ? '0 : index + 1'b1;

    // Dwell sequencing; wrap marks the edge where the last digit hands back to digit 0.
    always_comb begin
        state_nx = state;
        index_nx = index;
        cnt_nx   = cnt;
        wrap     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_nx = ST_ON;
                    index_nx = '0;
                    cnt_nx   = '0;
                end
            end
            ST_ON: begin
                if (!enable) begin
                    state_nx = ST_IDLE;
                    index_nx = '0;
                    cnt_nx   = '0;
                end else if (cnt == ON_LAST) begin
                    cnt_nx = '0;
                    if (BLANK_CYCLES > 0) begin
                        state_nx = ST_BLANK;
                    end else begin
                        index_nx = index_inc;
                        wrap     = (index == LAST_DIGIT);
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            ST_BLANK: begin
                if (!enable) begin
                    state_nx = ST_IDLE;
                    index_nx = '0;
                    cnt_nx   = '0;
                end else if (cnt == BLANK_LAST) begin
                    state_nx = ST_ON;
                    index_nx = index_inc;
                    cnt_nx   = '0;
                    wrap     = (index == LAST_DIGIT);
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                index_nx = '0;
                cnt_nx   = '0;
            end
        endcase
    end

    // Shadow only changes between frames (or while idle); a load on the wrap edge bypasses pending.
    always_comb begin
        shadow_value_nx  = shadow_value;
        shadow_dp_nx     = shadow_dp;
        pending_value_nx = pending_value;
        pending_dp_nx    = pending_dp;
        pending_valid_nx = pending_valid;
        if ((state == ST_IDLE) || wrap) begin
            if (load) begin
                shadow_value_nx = value;
                shadow_dp_nx    = dp;
            end else if (pending_valid) begin
                shadow_value_nx = pending_value;
                shadow_dp_nx    = pending_dp;
            end
            pending_valid_nx = 1'b0;
        end else if (load) begin
            pending_value_nx = value;
            pending_dp_nx    = dp;
            pending_valid_nx = 1'b1;
        end
    end

    always_comb begin
        zero_above = 1'b1;
        suppress   = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_above  = zero_above && (shadow_value_nx[4*k +: 4] == 4'd0);
            suppress[k] = zero_above;
        end
    end

    assign cur_nibble = shadow_value_nx[4*index_nx +: 4];

    seg7_decode u_decode (
        .nibble (cur_nibble),
        .seg_n  (dec_seg)
    );

    // Outputs are computed from next-state values so the registers line up with the state.
    always_comb begin
        an_n_nx  = '1;
        seg_n_nx = 7'h7F;
        dp_n_nx  = 1'b1;
        if (state_nx == ST_ON) begin
            an_n_nx  = ~(DIGIT0_SEL << index_nx);
            seg_n_nx = (LZS && suppress[index_nx]) ? 7'h7F : dec_seg;
            dp_n_nx  = ~shadow_dp_nx[index_nx];
        end
        if (BLANK_CYCLES > 0) begin
            last_cycle_nx = (state_nx == ST_BLANK) && (cnt_nx == BLANK_LAST);
        end else begin
            last_cycle_nx = (state_nx == ST_ON) && (cnt_nx == ON_LAST);
        end
        frame_done_nx = last_cycle_nx && (index_nx == LAST_DIGIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            index         <= '0;
            cnt           <= '0;
            shadow_value  <= '0;
            shadow_dp     <= '0;
            pending_value <= '0;
            pending_dp    <= '0;
            pending_valid <= 1'b0;
            an_n          <= '1;
            seg_n         <= 7'h7F;
            dp_n          <= 1'b1;
            frame_done    <= 1'b0;
        end else begin
            state         <= state_nx;
            index         <= index_nx;
            cnt           <= cnt_nx;
            shadow_value  <= shadow_value_nx;
            shadow_dp     <= shadow_dp_nx;
            pending_value <= pending_value_nx;
            pending_dp    <= pending_dp_nx;
            pending_valid <= pending_valid_nx;
            an_n          <= an_n_nx;
            seg_n         <= seg_n_nx;
            dp_n          <= dp_n_nx;
            frame_done    <= frame_done_nx;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench: two scanners (with and without dead time) share stimulus and are
// compared every cycle against a frame-arithmetic reference model.
module tb_display_scan_ctrl;

    localparam int D  = 4;
    localparam int SD = 3;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b1;
    logic        enable = 1'b0;
    logic        load   = 1'b0;
    logic [15:0] value  = '0;
    logic [3:0]  dp     = '0;

    logic [3:0] an0, an1;
    logic [6:0] seg0, seg1;
    logic       dpn0, dpn1, fd0, fd1;

    always #5 clk = ~clk;

    display_scan_ctrl #(.DIGITS(D), .SCAN_DIVISOR(SD), .BLANK_CYCLES(1), .LZS(1'b1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value), .dp(dp),
        .an_n(an0), .seg_n(seg0), .dp_n(dpn0), .frame_done(fd0)
    );

    display_scan_ctrl #(.DIGITS(D), .SCAN_DIVISOR(SD), .BLANK_CYCLES(0), .LZS(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value), .dp(dp),
        .an_n(an1), .seg_n(seg1), .dp_n(dpn1), .frame_done(fd1)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp_n;
        logic       fd;
    } obs_t;

    typedef struct packed {
        obs_t a;
        obs_t b;
    } pair_t;

    localparam obs_t BLANK_OBS = '{an: 4'hF, seg: 7'h7F, dp_n: 1'b1, fd: 1'b0};
    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    pair_t exp_q[$];
    int    total = 0;
    int    bad   = 0;

    bit          scanning [2];
    int          p        [2];
    logic [15:0] sh_v     [2];
    logic [15:0] pd_v     [2];
    logic [3:0]  sh_dp    [2];
    logic [3:0]  pd_dp    [2];
    bit          pv       [2];
    bit          commit_m;

    function automatic int blank_of(input int c);
        return (c == 0) ? 1 : 0;
    endfunction

    function automatic int frame_len(input int c);
        return D * (SD + blank_of(c));
    endfunction

    // Expected outputs derived from the position p within the scan and the shadow contents.
    function automatic obs_t expect_obs(input int c);
        obs_t o;
        int   per, d, msd;
        o   = BLANK_OBS;
        per = SD + blank_of(c);
        if (scanning[c]) begin
            d    = (p[c] / per) % D;
            o.fd = ((p[c] % frame_len(c)) == frame_len(c) - 1);
            if ((p[c] % per) < SD) begin
                msd = 0;
                for (int k = 0; k < D; k++) if (sh_v[c][4*k +: 4] != 4'd0) msd = k;
                o.an   = ~(4'b0001 << d);
                o.seg  = (d > msd) ? 7'h7F : HEX[sh_v[c][4*d +: 4]];
                o.dp_n = ~sh_dp[c][d];
            end
        end
        return o;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                scanning[c] = 1'b0;
                p[c]        = 0;
                sh_v[c]     = '0;
                pd_v[c]     = '0;
                sh_dp[c]    = '0;
                pd_dp[c]    = '0;
                pv[c]       = 1'b0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                commit_m = !scanning[c] || (enable && ((p[c] % frame_len(c)) == frame_len(c) - 1));
                if (commit_m) begin
                    if (load) begin
                        sh_v[c]  = value;
                        sh_dp[c] = dp;
                    end else if (pv[c]) begin
                        sh_v[c]  = pd_v[c];
                        sh_dp[c] = pd_dp[c];
                    end
                    pv[c] = 1'b0;
                end else if (load) begin
                    pd_v[c]  = value;
                    pd_dp[c] = dp;
                    pv[c]    = 1'b1;
                end
                if (!scanning[c]) begin
                    if (enable) begin
                        scanning[c] = 1'b1;
                        p[c]        = 0;
                    end
                end else if (!enable) begin
                    scanning[c] = 1'b0;
                end else begin
                    p[c] = p[c] + 1;
                end
            end
            exp_q.push_back('{a: expect_obs(0), b: expect_obs(1)});
        end
    end

    task automatic check_output(input string name, input obs_t act, input obs_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got an_n=%b seg_n=%b dp_n=%b fd=%b, need an_n=%b seg_n=%b dp_n=%b fd=%b",
                     name, $time, act.an, act.seg, act.dp_n, act.fd, exp.an, exp.seg, exp.dp_n, exp.fd);
        end
    endtask

    // Monitor: clk low one unit after the event means rst_n fell between clock edges.
    initial begin
        pair_t e;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            if (clk == 1'b0) begin
                check_output("async_reset_blank0", {an0, seg0, dpn0, fd0}, BLANK_OBS);
                check_output("async_reset_blank1", {an1, seg1, dpn1, fd1}, BLANK_OBS);
            end else if (!rst_n) begin
                check_output("reset_hold0", {an0, seg0, dpn0, fd0}, BLANK_OBS);
                check_output("reset_hold1", {an1, seg1, dpn1, fd1}, BLANK_OBS);
            end else if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL scoreboard_empty at %0t: got no expectation, need one per cycle", $time);
            end else begin
                e = exp_q.pop_front();
                check_output("scan_blank1", {an0, seg0, dpn0, fd0}, e.a);
                check_output("scan_blank0", {an1, seg1, dpn1, fd1}, e.b);
            end
        end
    end

    task automatic apply_stimulus(input logic en, input logic ld, input logic [15:0] v, input logic [3:0] d);
        @(negedge clk);
        enable = en;
        load   = ld;
        value  = v;
        dp     = d;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        load = 1'b0;
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] mask;
        #1 rst_n = 1'b0;
        repeat (3) apply_stimulus(1'b1, 1'b0, 16'h0000, 4'h0);

        @(negedge clk);
        rst_n = 1'b1;
        load  = 1'b1;
        value = 16'h1234;
        repeat (40) apply_stimulus(1'b1, 1'b0, 16'h1234, 4'h0);

        apply_stimulus(1'b1, 1'b1, 16'h0050, 4'b1000);
        repeat (40) apply_stimulus(1'b1, 1'b0, 16'h0050, 4'b1000);

        repeat (5) apply_stimulus(1'b1, 1'b0, 16'h0050, 4'b1000);
        apply_stimulus(1'b1, 1'b1, 16'hAAAA, 4'b0101);
        repeat (3) apply_stimulus(1'b1, 1'b0, 16'hAAAA, 4'b0101);
        apply_stimulus(1'b1, 1'b1, 16'hBBBB, 4'b0010);
        repeat (40) apply_stimulus(1'b1, 1'b0, 16'hBBBB, 4'b0010);

        for (int i = 0; i < 40 && !fd0; i++) apply_stimulus(1'b1, 1'b0, 16'hBBBB, 4'b0010);
        load  = 1'b1;
        value = 16'hC0DE;
        dp    = 4'b0001;
        repeat (24) apply_stimulus(1'b1, 1'b0, 16'hC0DE, 4'b0001);

        for (int i = 0; i < 40 && an0 != 4'b1011; i++) apply_stimulus(1'b1, 1'b0, 16'hC0DE, 4'b0001);
        enable = 1'b0;
        repeat (3) apply_stimulus(1'b0, 1'b0, 16'hC0DE, 4'b0001);
        repeat (24) apply_stimulus(1'b1, 1'b0, 16'hC0DE, 4'b0001);

        for (int i = 0; i < 40 && an1 == 4'b1111; i++) apply_stimulus(1'b1, 1'b1, 16'h0F00, 4'b0100);
        reset_pulse();
        repeat (30) apply_stimulus(1'b1, 1'b0, 16'h0F00, 4'b0100);

        for (int i = 0; i < 2500; i++) begin
            case ($urandom_range(0, 3))
                0:       mask = 16'h000F;
                1:       mask = 16'h00FF;
                2:       mask = 16'h0FFF;
                default: mask = 16'hFFFF;
            endcase
            if ($urandom_range(0, 299) == 0) begin
                reset_pulse();
            end else begin
                apply_stimulus(($urandom_range(0, 39) != 0), ($urandom_range(0, 9) == 0),
                               16'($urandom) & mask, 4'($urandom));
            end
        end

        repeat (5) apply_stimulus(1'b1, 1'b0, 16'h0000, 4'h0);
        @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
